// File: rtl/frame_echo_pkg.sv
// -----------------------------------------------------------------------------
// frame_echo_pkg
// Shared Ethernet constants, the parsed-header struct, the echo FSM state
// encoding and small helpers used by the frame echo block.
// -----------------------------------------------------------------------------
package frame_echo_pkg;

    localparam int unsigned ETH_HDR_BYTES   = 14;
    localparam logic [10:0] ETH_MIN_PAYLOAD = 11'd46;
    localparam logic [10:0] ETH_MAX_LEN     = 11'd1500;

    // Parsed header as delivered by the receive path, MSB first on the wire.
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } eth_header_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        PAD,
        DONE
    } echo_state_e;

    // Byte idx (0 = first on the wire) of a 14-byte header image.
    function automatic logic [7:0] hdr_byte(input logic [111:0] hdr,
                                            input logic [3:0]   idx);
        logic [111:0] shifted;
        shifted = hdr << {idx, 3'b000};
        return shifted[111:104];
    endfunction

    // Type values up to max_len are payload lengths; larger ones are
    // EtherTypes, for which a fixed payload size is assumed.
    function automatic logic [10:0] payload_len(input logic [15:0] eth_type,
                                                input logic [10:0] max_len,
                                                input logic [10:0] default_len);
        if (eth_type <= {5'b0, max_len}) begin
            return eth_type[10:0];
        end
        return default_len;
    endfunction

endpackage

// File: rtl/frame_echo_skid.sv
// -----------------------------------------------------------------------------
// echo_skid
// Two-entry 8-bit FIFO decoupling RX-buffer read latency from TX backpressure.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (pointers/count only)
//   push, din    write strobe and data
//   pop          read strobe (head is consumed)
//   dout         head entry, valid while count != 0
//   count        occupancy 0..2
// A push at count=2 only happens together with a pop: the reader reserves the
// slot before issuing the buffer read.
// -----------------------------------------------------------------------------
module echo_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic [1:0] count
);

    logic [7:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block updates from the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the data array is deliberately not reset; occupancy is tracked by
    // count_q, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/frame_echo.sv
// -----------------------------------------------------------------------------
// frame_echo
// Drains one parsed header plus its buffered payload and transmits a reply
// frame on a byte-wide AXI-Stream: dst = received src, src = LOCAL_MAC,
// type copied, payload echoed byte for byte.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rx_header[111:0]  {dst_mac, src_mac, eth_type}, valid while brx_empty=0
//   brx_empty         RX buffer empty
//   rx_data[7:0]      RX buffer data, valid the cycle after brx_rd_en
//   brx_rd_en         RX buffer pop request
//   tx_axis_*         reply byte stream (tdata/tvalid/tlast out, tready in)
//   frame_done        one-cycle pulse after the tlast handshake
// Build option:
//   ECHO_PAD_EN       when defined, payloads shorter than 46 bytes are padded
//                     with 0x00 to a 60-byte frame; otherwise sent unpadded.
// -----------------------------------------------------------------------------
module frame_echo
    import frame_echo_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [10:0] DEFAULT_LEN = 11'd46,
    parameter logic [10:0] MAX_LEN     = 11'd1500
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [111:0] rx_header,
    input  logic         brx_empty,
    input  logic [7:0]   rx_data,
    output logic         brx_rd_en,
    output logic [7:0]   tx_axis_tdata,
    output logic         tx_axis_tvalid,
    output logic         tx_axis_tlast,
    input  logic         tx_axis_tready,
    output logic         frame_done
);

    echo_state_e state_q, state_d;

    eth_header_t  hdr_in;
    logic [47:0]  src_mac_q;
    logic [15:0]  eth_type_q;
    logic [10:0]  len_q;
    logic [3:0]   hdr_cnt_q;
    logic [10:0]  pay_cnt_q;
    logic [10:0]  reads_q;
    logic         in_flight_q;

    logic [111:0] reply_hdr;
    logic [1:0]   skid_count;
    logic [7:0]   skid_dout;
    logic         skid_pop;
    logic [2:0]   occupancy;
    logic         pad_needed;
    logic         hdr_last;
    logic         pay_last;
    logic         unused_dst;

    assign hdr_in     = rx_header;
    assign unused_dst = ^hdr_in.dst_mac;
    assign reply_hdr  = {src_mac_q, LOCAL_MAC, eth_type_q};

`ifdef ECHO_PAD_EN
    logic pad_last;
    assign pad_needed = (len_q < ETH_MIN_PAYLOAD);
    assign pad_last   = (pay_cnt_q == ETH_MIN_PAYLOAD - 11'd1);
`else
    assign pad_needed = 1'b0;
`endif

    assign hdr_last = (hdr_cnt_q == 4'(ETH_HDR_BYTES - 1));
    assign pay_last = (pay_cnt_q == len_q - 11'd1);

    // Payload bytes leave the skid only on a PAY handshake.
    assign skid_pop = (state_q == PAY) && tx_axis_tvalid && tx_axis_tready;

    // Slots already committed after this cycle's pop; a read is issued only
    // when its byte is guaranteed a skid entry on arrival.
    assign occupancy = {1'b0, skid_count} + {2'b00, in_flight_q} - {2'b00, skid_pop};

    assign brx_rd_en = ((state_q == HDR) || (state_q == PAY)) && !brx_empty
                       && (reads_q < len_q) && (occupancy < 3'd2);

    echo_skid u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_flight_q),
        .din   (rx_data),
        .pop   (skid_pop),
        .dout  (skid_dout),
        .count (skid_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_mac_q   <= '0;
            eth_type_q  <= '0;
            len_q       <= '0;
            hdr_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            reads_q     <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= brx_rd_en;

            if (state_q == IDLE) begin
                hdr_cnt_q <= '0;
                pay_cnt_q <= '0;
                reads_q   <= '0;
                if (!brx_empty) begin
                    src_mac_q  <= hdr_in.src_mac;
                    eth_type_q <= hdr_in.eth_type;
                    len_q      <= payload_len(hdr_in.eth_type, MAX_LEN, DEFAULT_LEN);
                end
            end else if (brx_rd_en) begin
                reads_q <= reads_q + 11'd1;
            end

            if (tx_axis_tvalid && tx_axis_tready) begin
                if (state_q == HDR) hdr_cnt_q <= hdr_cnt_q + 4'd1;
                else                pay_cnt_q <= pay_cnt_q + 11'd1;
            end
        end
    end

    // NOTE: every output and next-state variable gets a default before the
    // case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        tx_axis_tvalid = 1'b0;
        tx_axis_tdata  = 8'h00;
        tx_axis_tlast  = 1'b0;
        frame_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!brx_empty) state_d = HDR;
            end

            HDR: begin
                tx_axis_tvalid = 1'b1;
                tx_axis_tdata  = hdr_byte(reply_hdr, hdr_cnt_q);
                tx_axis_tlast  = hdr_last && (len_q == 11'd0) && !pad_needed;
                if (tx_axis_tready && hdr_last) begin
                    if (len_q != 11'd0)  state_d = PAY;
                    else if (pad_needed) state_d = PAD;
                    else                 state_d = DONE;
                end
            end

            PAY: begin
                tx_axis_tvalid = (skid_count != 2'd0);
                tx_axis_tdata  = skid_dout;
                tx_axis_tlast  = tx_axis_tvalid && pay_last && !pad_needed;
                if (tx_axis_tvalid && tx_axis_tready && pay_last) begin
                    state_d = pad_needed ? PAD : DONE;
                end
            end

`ifdef ECHO_PAD_EN
            PAD: begin
                tx_axis_tvalid = 1'b1;
                tx_axis_tlast  = pad_last;
                if (tx_axis_tready && pad_last) state_d = DONE;
            end
`endif

            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_echo.sv
// -----------------------------------------------------------------------------
// tb_frame_echo
// Randomized bench for frame_echo. A queue models the RX buffer (one-cycle
// read latency); the expected reply is built from the frame rules as a byte
// queue and compared with the captured TX stream.
// -----------------------------------------------------------------------------
module tb_frame_echo;

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [111:0] rx_header = '0;
    logic         brx_empty = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         brx_rd_en;
    logic [7:0]   tx_axis_tdata;
    logic         tx_axis_tvalid;
    logic         tx_axis_tlast;
    logic         tx_axis_tready = 1'b0;
    logic         frame_done;

    frame_echo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_header      (rx_header),
        .brx_empty      (brx_empty),
        .rx_data        (rx_data),
        .brx_rd_en      (brx_rd_en),
        .tx_axis_tdata  (tx_axis_tdata),
        .tx_axis_tvalid (tx_axis_tvalid),
        .tx_axis_tlast  (tx_axis_tlast),
        .tx_axis_tready (tx_axis_tready),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] buf_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] obs_q[$];
    bit         obs_last_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tlast_cnt, tlast_cyc, first_cyc, done_cnt, done_cyc;
    int rd_cnt, stall_viol, underflow;
    int rdy_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RX buffer model: a pop requested in cycle N presents data in cycle N+1.
    initial begin
        bit take;
        forever begin
            @(negedge clk);
            take = brx_rd_en;
            @(posedge clk);
            #1;
            if (take) begin
                if (buf_q.size() == 0) underflow++;
                else                   rx_data = buf_q.pop_front();
            end
            brx_empty = (buf_q.size() == 0);
        end
    end

    // Backpressure: 0 = always ready, 1 = toggling with random stalls, 2 = random.
    initial begin
        bit tog;
        tog = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            case (rdy_mode)
                0:       tx_axis_tready = 1'b1;
                1:       tx_axis_tready = tog && ($urandom_range(0, 4) != 0);
                default: tx_axis_tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Stream monitor: captures handshakes and checks stall stability.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;
        prev_stall = 1'b0;
        prev_d     = 8'h00;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!tx_axis_tvalid || tx_axis_tdata !== prev_d
                                   || tx_axis_tlast !== prev_l)) stall_viol++;
                if (tx_axis_tvalid && tx_axis_tready) begin
                    if (obs_q.size() == 0) first_cyc = cyc;
                    obs_q.push_back(tx_axis_tdata);
                    obs_last_q.push_back(tx_axis_tlast);
                    if (tx_axis_tlast) begin
                        tlast_cnt++;
                        tlast_cyc = cyc;
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (brx_rd_en) rd_cnt++;
                prev_stall = tx_axis_tvalid && !tx_axis_tready;
                prev_d     = tx_axis_tdata;
                prev_l     = tx_axis_tlast;
            end
        end
    end

    task automatic clear_obs();
        obs_q.delete();
        obs_last_q.delete();
        tlast_cnt = 0; tlast_cyc = 0; first_cyc = 0;
        done_cnt = 0; done_cyc = 0;
        rd_cnt = 0; stall_viol = 0; underflow = 0;
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    // Sends one frame whose payload is pay_q. gap_after>0 withholds the
    // payload beyond that many bytes until 5 idle cycles have been observed.
    task automatic run_frame(input logic [47:0] src, input logic [15:0] etype,
                             input int gap_after, input string name);
        logic [7:0] exp_q[$];
        int len, budget, mis, first_bad, n_valid, n_first;
        bit gap_done;

        clear_obs();
        len     = (etype <= 16'd1500) ? int'(etype) : 46;
        n_first = (gap_after != 0) ? gap_after : pay_q.size();

        @(posedge clk);
        #1;
        rx_header = {{$urandom, $urandom}, src, etype};
        for (int i = 0; i < n_first; i++) buf_q.push_back(pay_q[i]);

        gap_done = (gap_after == 0);
        budget   = 0;
        while (done_cnt == 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (!gap_done && obs_q.size() == 14 + gap_after) begin
                n_valid = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (tx_axis_tvalid) n_valid++;
                end
                check({name, " gap tvalid cycles"}, n_valid, 0);
                @(posedge clk);
                #1;
                for (int i = gap_after; i < pay_q.size(); i++) buf_q.push_back(pay_q[i]);
                gap_done = 1'b1;
            end
        end
        check({name, " frame_done seen"}, 32'(done_cnt != 0), 1);

        for (int i = 5; i >= 0; i--) exp_q.push_back(src[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(LOCAL[8*i +: 8]);
        exp_q.push_back(etype[15:8]);
        exp_q.push_back(etype[7:0]);
        for (int i = 0; i < len; i++) exp_q.push_back(pay_q[i]);
`ifdef ECHO_PAD_EN
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif

        mis = 0;
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                mis++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check({name, " byte count"}, obs_q.size(), exp_q.size());
        check({name, " byte mismatches"}, mis, 0);
        check({name, " first bad byte idx"}, first_bad, -1);
        check({name, " tlast count"}, tlast_cnt, 1);
        if (obs_last_q.size() > 0)
            check({name, " tlast on final byte"}, 32'(obs_last_q[obs_last_q.size()-1]), 1);
        check({name, " frame_done delay"}, done_cyc - tlast_cyc, 1);
        check({name, " frame_done pulses"}, done_cnt, 1);
        check({name, " buffer reads"}, rd_cnt, len);
        check({name, " buffer left"}, buf_q.size(), 0);
        check({name, " stall stability"}, stall_viol, 0);
        check({name, " underflow reads"}, underflow, 0);
        if (rdy_mode == 0 && gap_after == 0)
            check({name, " full-rate cycles"}, tlast_cyc - first_cyc, exp_q.size() - 1);

        repeat (2) @(posedge clk);
    endtask

    initial begin
        int budget;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tvalid", 32'(tx_axis_tvalid), 0);
        check("reset tlast", 32'(tx_axis_tlast), 0);
        check("reset brx_rd_en", 32'(brx_rd_en), 0);
        check("reset frame_done", 32'(frame_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Short length frame
        rdy_mode = 0;
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(48'hAA_BB_CC_DD_EE_FF, 16'h0004, 0, "len4");

        // EtherType frame: DEFAULT_LEN bytes consumed
        pay_q.delete();
        for (int i = 0; i < 46; i++) pay_q.push_back(8'(i));
        run_frame(48'h11_22_33_44_55_66, 16'h0800, 0, "etype");

        // Toggling backpressure with random stalls
        rdy_mode = 1;
        fill_random(64);
        run_frame(48'h0A_0B_0C_0D_0E_0F, 16'd64, 0, "stall64");

        // Buffer underflow after payload byte 3
        rdy_mode = 0;
        fill_random(8);
        run_frame(48'hDE_AD_BE_EF_00_01, 16'd8, 3, "gap8");

        // Two-byte payload (padded to 60 bytes when padding is built in)
        pay_q = '{8'h5A, 8'hA5};
        run_frame(48'h12_34_56_78_9A_BC, 16'd2, 0, "len2");

        // Reset during payload byte 20 of 100
        clear_obs();
        fill_random(100);
        @(posedge clk);
        #1;
        rx_header = {48'h0, 48'hCA_FE_00_00_00_01, 16'd100};
        for (int i = 0; i < 100; i++) buf_q.push_back(pay_q[i]);
        budget = 0;
        while (obs_q.size() < 34 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("midreset reached byte 20", obs_q.size(), 34);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        buf_q.delete();
        brx_empty = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset tvalid", 32'(tx_axis_tvalid), 0);
        check("midreset tlast", 32'(tx_axis_tlast), 0);
        check("midreset brx_rd_en", 32'(brx_rd_en), 0);
        check("midreset frame_done", 32'(frame_done), 0);
        repeat (2) @(posedge clk);

        fill_random(10);
        run_frame(48'h55_44_33_22_11_00, 16'd10, 0, "after_reset");

        // Random frames under random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) begin
            int n;
            n = $urandom_range(1, 70);
            fill_random(n);
            run_frame({16'($urandom), 32'($urandom)}, 16'(n), 0, $sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_echo.md
Name: frame_echo

Overview:
- Downstream consumer of the receive path.
- Drains a parsed Ethernet header and its buffered payload and emits a reply frame on a byte-wide AXI-Stream TX interface to the tri-mode MAC.
- Reply frame: destination MAC = received source MAC; source MAC = LOCAL_MAC; EtherType/length copied; payload echoed byte-for-byte.
- Paces buffer reads with brx_rd_en and tolerates MAC backpressure without losing or duplicating bytes.

Parameters:
LOCAL_MAC, 48'h02_00_00_00_00_01, source MAC inserted in every reply
DEFAULT_LEN, 11'd46, payload byte count used when the received type field is an EtherType (>1500)
MAX_LEN, 11'd1500, largest type value treated as a payload length

Ports:
clk  input  1  system clock
rst_n  input  1  reset, active-low, synchronous
rx_header  input  header (112 b)  parsed header {dst_mac, src_mac, eth_type}; stable while brx_empty=0 for the current frame
brx_empty  input  1  RX buffer empty
rx_data  input  8  RX buffer read data, valid the cycle after brx_rd_en
brx_rd_en  output  1  RX buffer pop request
tx_axis_tdata  output  8  reply byte
tx_axis_tvalid  output  1  reply byte valid
tx_axis_tlast  output  1  last reply byte
tx_axis_tready  input  1  MAC accepts byte
frame_done  output  1  one-cycle pulse after the tlast handshake

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low.
- Reset values: all outputs 0; state IDLE; counters 0; skid empty.
- States:
  - IDLE -> HDR when brx_empty=0. Latch rx_header, hdr_cnt=0.
  - Latch payload length: len = eth_type[10:0] if eth_type<=MAX_LEN, else DEFAULT_LEN.
- HDR:
  - Emits 14 bytes, MSB first: rx_header.src_mac[47:0], LOCAL_MAC[47:0], eth_type[15:0].
  - hdr_cnt (4 b) advances only on tvalid&tready.
  - After byte 13 handshakes: PAY if len>0; PAD if padding is required (see feature); otherwise DONE.
  - If len=0 and no padding, tlast is asserted on header byte 13.
- PAY:
  - Bytes come from the 2-entry skid; tvalid = skid non-empty.
  - pay_cnt (11 b) counts handshakes; tlast on byte len-1 when no padding follows.
- Buffer reads:
  - brx_rd_en=1 when state∈{HDR,PAY}, brx_empty=0, reads_issued<len, and (skid_count + in_flight − pop_this_cycle)<2.
  - Prefetch starts during HDR.
  - Sustained 1 byte/cycle when tready=1 and the buffer is non-empty.
  - Bytes must never be dropped or duplicated under any tready pattern.
- Buffer underflow mid-payload: tvalid drops until data arrives; no timeout.
- AXIS rules:
  - tdata, tlast are held stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a handshake, except on reset.
- DONE: frame_done=1 for one cycle -> IDLE. The next frame may start the following cycle.
- tlast coincides with exactly one handshake per frame.
- Reset mid-frame: immediate return to IDLE. tvalid/tlast/brx_rd_en=0 in the cycle following the reset sample. Skid flushed; in-flight read discarded.
- Frame byte total = 14 + len (+ pad). Max 1514 without padding.

Optional Feature:
ECHO_PAD_EN
- Defined: when len<46, state PAD follows PAY (or HDR if len=0). PAD emits 0x00 bytes until 46 payload bytes have been sent (60-byte frame); tlast is on the final pad byte.
- Undefined: PAD state absent; frames shorter than 60 bytes go out unpadded (MAC pads).

Decomposition:
- Package defines (existing) gains:
  - ETH_HDR_BYTES=14, ETH_MIN_PAYLOAD=46, ETH_MAX_LEN=1500.
  - enum echo_state_e {IDLE, HDR, PAY, PAD, DONE}.
  - The header struct is reused unchanged.
- Sub-module echo_skid: 2-entry 8-bit FIFO.
  - Ports: push, din, pop, dout, count[1:0].
  - Simultaneous push/pop at count=2 is legal: push only arrives for a reserved slot.

Test Plan:
- Header src=AA:BB:CC:DD:EE:FF, type=0x0004, payload 11 22 33 44, tready=1 -> 18 bytes: AA..FF, 02 00 00 00 00 01, 00 04, 11 22 33 44. tlast on byte 18; frame_done one cycle later; brx_rd_en high exactly 4 cycles.
- Type=0x0800, 46 buffered bytes 0x00..0x2D -> 60 bytes out; payload count equals DEFAULT_LEN; buffer ends empty.
- Length 64, tready toggling 1-0-1-0 plus random stalls -> output payload identical to input; tdata stable during every stall.
- Length 8, brx_empty forced high for 5 cycles after byte 3 -> tvalid low during the gap; bytes 4-8 follow in order; no duplicate reads.
- ECHO_PAD_EN, length 2, payload 5A A5 -> 60 bytes, bytes 17-60 = 0x00, tlast on byte 60. Without the macro: 16 bytes, tlast on byte 16.
- rst_n low for one cycle during payload byte 20 of 100 -> outputs 0 the next cycle; a new frame then echoes correctly from its first header byte.
